muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It generalises the ALU decoder's MULT/DIV + hien/loen path: parametrised datapath width, signed and unsigned ops (MULT/MULTU/DIV/DIVU), a busy/done handshake for the hazard unit, MTHI/MTLO writes and pipeline-flush abort. It sits beside the ALU in EX; MFHI/MFLO read `hi`/`lo` directly and stall while `busy`.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_0   = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_1   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op_s, a_sgn_s, b_sgn_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic               res_neg_s;

  // Operand magnitudes, single-step datapaths and sign-corrected results.
  always_comb begin
    signed_op_s = SIGNED_EN && !op[0];
    a_sgn_s     = signed_op_s && a[WIDTH-1];
    b_sgn_s     = signed_op_s && b[WIDTH-1];
    a_mag_s     = a_sgn_s ? (~a + ONE_W) : a;
    b_mag_s     = b_sgn_s ? (~b + ONE_W) : b;

    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : ZERO_W)};
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};

    // Partial remainder < divisor, so the WIDTH+1 bit trial's MSB is a valid borrow flag.
    div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    div_rem_s   = div_trial_s[WIDTH] ? {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]}
                                     : div_trial_s[WIDTH-1:0];
    div_next_s  = {div_rem_s, acc_q[WIDTH-2:0], ~div_trial_s[WIDTH]};

    res_neg_s   = a_neg_q ^ b_neg_q;
    prod_s      = res_neg_s ? (~acc_q + ONE_2W) : acc_q;
    quo_s       = res_neg_s ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rem_s       = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    b_d      = b_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wdata;
        else       hi_d = hi_q;
        if (wr_lo) lo_d = wdata;
        else       lo_d = lo_q;
        if (start && !flush) begin
          state_d  = RUN;
          count_d  = CNT_0;
          is_div_d = op[1];
          a_neg_d  = a_sgn_s;
          b_neg_d  = b_sgn_s;
          a_raw_d  = a;
          b_d      = b_mag_s;
          acc_d    = {ZERO_W, a_mag_s};
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          if (count_q == LAST) state_d = FIX;
          else                 count_d = count_q + CNT_1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_s;
          end else if (b_q == ZERO_W) begin
            hi_d = a_raw_q;
            lo_d = ONES_W;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= CNT_0;
      acc_q    <= ZERO_2W;
      b_q      <= ZERO_W;
      a_raw_q  <= ZERO_W;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= ZERO_W;
      lo_q     <= ZERO_W;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: signed/unsigned multiply and divide,
// divide by zero, flush, busy-time inputs, async reset and SIGNED_EN=0.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         flush, wr_hi, wr_lo;
  logic         busy, done, u_busy, u_done;
  logic [W-1:0] hi, lo, u_hi, u_lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(u_busy), .done(u_done), .hi(u_hi), .lo(u_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op, checks busy over cycles 1..W+1 and the result at cycle W+2.
  // With inject set, a stray start is pulsed at cycle 5.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input bit inject);
    logic ok;
    ok    = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    for (int c = 1; c <= W + 1; c++) begin
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      if (inject && c == 5) begin
        start = 1'b1; op = 2'b01; a = 32'h0000_00FF; b = 32'h0000_00FF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_busywin"}, {31'h0, ok}, 32'h1);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_busy0"}, {31'h0, busy}, 32'h0);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    logic seen_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'h0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    #11 reset = 1'b0;
    tick();

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_nn", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negb", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div0", 2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div0_neg", 2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
    run_op("divu0", 2'b11, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    tick();
    check("done_pulse", {31'h0, done}, 32'h0);

    // Preload, then flush a running MULT; busy-time start/wr_lo must be dropped.
    wr_hi = 1'b1; wdata = 32'h5; tick();
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h6; tick();
    wr_lo = 1'b0;
    check("mthi", hi, 32'h5);
    check("mtlo", lo, 32'h6);
    op = 2'b00; a = 32'h3; b = 32'h7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      start = (c == 5);
      wr_lo = (c == 6);
      wdata = 32'h0000_0099;
      tick();
    end
    start = 1'b0; wr_lo = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'h0);
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("flush_nodone", {31'h0, seen_done}, 32'h0);
    check("flush_hi", hi, 32'h5);
    check("flush_lo", lo, 32'h6);

    // Flush with start in IDLE drops the start but lets MTHI through.
    flush = 1'b1; start = 1'b1; wr_hi = 1'b1; wdata = 32'h77; op = 2'b00; a = 32'h2; b = 32'h2;
    tick();
    flush = 1'b0; start = 1'b0; wr_hi = 1'b0;
    check("fl_start_busy", {31'h0, busy}, 32'h0);
    check("fl_mthi", hi, 32'h77);

    // Asynchronous reset at cycle 20 of a DIV.
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    #3 reset = 1'b0;
    tick();
    run_op("div_after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Same MULT on both instances: SIGNED_EN=0 must behave as MULTU.
    run_op("mult_s", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    check("unsig_done", {31'h0, u_done}, 32'h1);
    check("unsig_hi", u_hi, 32'h0000_0001);
    check("unsig_lo", u_lo, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
